// File: rtl/instr_sequencer_if.sv
// Instruction memory and register file bus for instr_sequencer.
// master = sequencer side, slave = memory / register file side.
interface instr_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [7:0]          imem_data;
  logic                read_reg1;
  logic                read_reg2;
  logic [7:0]          read_data1;
  logic [7:0]          read_data2;
  logic                write_reg;
  logic [7:0]          write_data;
  logic                write_en;

  modport master (
    output imem_req, imem_addr,
    output read_reg1, read_reg2,
    output write_reg, write_data, write_en,
    input  imem_ack, imem_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  imem_req, imem_addr,
    input  read_reg1, read_reg2,
    input  write_reg, write_data, write_en,
    output imem_ack, imem_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer, 8-bit datapath.
// Define INSTR_SEQ_SATURATE_EN for saturating ADD/SUB instead of wrapping.
module instr_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  instr_sequencer_if.master   bus,
  output logic                busy,
  output logic                halted,
  output logic [PC_WIDTH-1:0] pc
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] EXECUTE   = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] HALTED    = 3'd5;

  localparam logic [PC_WIDTH-1:0] PC_ONE =
    {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0] state;
  logic [7:0] instr;
  logic [7:0] result;
  logic [7:0] alu;
  logic [7:0] add_res;
  logic [7:0] sub_res;
  logic [1:0] op;
  logic       unused_fields;

  assign op            = instr[7:6];
  assign unused_fields = ^instr[2:0];

`ifdef INSTR_SEQ_SATURATE_EN
  logic [8:0] sum;
  logic [8:0] diff;

  assign sum  = {1'b0, bus.read_data1} + {1'b0, bus.read_data2};
  assign diff = {1'b0, bus.read_data1} - {1'b0, bus.read_data2};
  // Bit 8 flags carry out of ADD and borrow out of SUB.
  assign add_res = sum[8]  ? 8'hFF : sum[7:0];
  assign sub_res = diff[8] ? 8'h00 : diff[7:0];
`else
  assign add_res = bus.read_data1 + bus.read_data2;
  assign sub_res = bus.read_data1 - bus.read_data2;
`endif

  always_comb begin
    alu = result;
    unique case (op)
      2'b00:   alu = add_res;
      2'b01:   alu = sub_res;
      2'b10:   alu = {3'b000, instr[4:0]};
      default: alu = result;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pc            <= '0;
      instr         <= '0;
      result        <= '0;
      bus.read_reg1 <= 1'b0;
      bus.read_reg2 <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            instr         <= bus.imem_data;
            pc            <= pc + PC_ONE;
            bus.read_reg1 <= bus.imem_data[4];
            bus.read_reg2 <= bus.imem_data[3];
            state         <= DECODE;
          end
        end
        DECODE: begin
          state <= (op == 2'b11) ? HALTED : EXECUTE;
        end
        EXECUTE: begin
          result <= alu;
          state  <= WRITEBACK;
        end
        WRITEBACK: begin
          state <= FETCH;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req   = (state == FETCH);
  assign bus.imem_addr  = pc;
  assign bus.write_en   = (state == WRITEBACK);
  assign bus.write_reg  = instr[5];
  assign bus.write_data = result;

  assign busy   = (state == FETCH)   ||
                  (state == DECODE)  ||
                  (state == EXECUTE) ||
                  (state == WRITEBACK);
  assign halted = (state == HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: program-stream reference model,
// randomized programs, ack delays, reset aborts and pc wrap.
module tb_instr_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy;
  logic       halted;
  logic [7:0] pc;

  instr_sequencer_if #(.PC_WIDTH(8)) bus();

  instr_sequencer #(.PC_WIDTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .halted  (halted),
    .pc      (pc)
  );

  always #5 clock = ~clock;

  logic [7:0] rf    [2];
  logic [7:0] mregs [2];
  logic [7:0] prog  [300];

  assign bus.read_data1 = rf[bus.read_reg1];
  assign bus.read_data2 = rf[bus.read_reg2];

  int checks = 0;
  int errors = 0;
  int first_wb;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rnd_ins();
    logic [7:0] v;
    v = 8'($urandom);
    v[7:6] = 2'($urandom_range(2, 0));
    return v;
  endfunction

  // Architectural result of one instruction on the model registers.
  function automatic logic [7:0] ref_exec(input logic [7:0] ins);
    int a;
    int b;
    int r;
    logic s1;
    logic s2;
    s1 = ins[4];
    s2 = ins[3];
    a = int'(mregs[s1]);
    b = int'(mregs[s2]);
    case (ins[7:6])
      2'b00: begin
        r = a + b;
`ifdef INSTR_SEQ_SATURATE_EN
        if (r > 255) r = 255;
`endif
      end
      2'b01: begin
        r = a - b;
`ifdef INSTR_SEQ_SATURATE_EN
        if (r < 0) r = 0;
`endif
      end
      default: r = int'(ins[4:0]);
    endcase
    return r[7:0];
  endfunction

  task automatic set_regs(input logic [7:0] a, input logic [7:0] b);
    rf[0] = a;
    rf[1] = b;
    mregs[0] = a;
    mregs[1] = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    bus.imem_ack = 1'b0;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_write_reg", bus.write_reg, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_read_reg1", bus.read_reg1, 0);
    chk("rst_read_reg2", bus.read_reg2, 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Runs prog[] as a fetch stream from pc 0 until HALT, acting as
  // memory (ack after lo..hi wait cycles) and checking every cycle.
  task automatic run_prog(input int lo, input int hi, input int budget);
    int cyc;
    int dly;
    int k;
    int exp_wb;
    int halt_cyc;
    int fetch_from;
    logic [7:0] pcm;
    logic [7:0] ins;
    logic [7:0] exp_data;
    logic exp_rd;
    logic exp_rs;
    logic exp_rt;
    bit done;
    cyc = 0;
    k = 0;
    exp_wb = -1;
    halt_cyc = -1;
    fetch_from = 1;
    pcm = 8'h00;
    exp_data = 8'h00;
    exp_rd = 1'b0;
    exp_rs = 1'b0;
    exp_rt = 1'b0;
    done = 1'b0;
    first_wb = -1;
    dly = $urandom_range(hi, lo);
    @(negedge clock);
    start = 1'b1;
    while (!done && cyc < budget) begin
      @(negedge clock);
      cyc++;
      start = ($urandom_range(3, 0) == 0);
      chk("write_en", bus.write_en, cyc == exp_wb);
      if (cyc == exp_wb) begin
        chk("write_reg", bus.write_reg, exp_rd);
        chk("write_data", bus.write_data, exp_data);
        mregs[exp_rd] = exp_data;
        if (first_wb < 0) first_wb = cyc;
      end
      if (bus.write_en) rf[bus.write_reg] = bus.write_data;
      if (exp_wb > 0 && (cyc == exp_wb - 1 || cyc == exp_wb - 2)) begin
        chk("read_reg1", bus.read_reg1, exp_rs);
        chk("read_reg2", bus.read_reg2, exp_rt);
      end
      chk("busy", busy, halt_cyc < 0 || cyc < halt_cyc);
      chk("halted", halted, halt_cyc >= 0 && cyc >= halt_cyc);
      chk("pc", pc, pcm);
      if (fetch_from >= 0 && cyc >= fetch_from) begin
        chk("imem_req", bus.imem_req, 1);
        chk("imem_addr", bus.imem_addr, pcm);
        if (dly == 0) begin
          ins = prog[k];
          k++;
          bus.imem_ack = 1'b1;
          bus.imem_data = ins;
          pcm = pcm + 8'h01;
          fetch_from = -1;
          dly = $urandom_range(hi, lo);
          if (ins[7:6] == 2'b11) begin
            halt_cyc = cyc + 2;
          end else begin
            exp_wb = cyc + 3;
            exp_rd = ins[5];
            exp_rs = ins[4];
            exp_rt = ins[3];
            exp_data = ref_exec(ins);
            fetch_from = cyc + 4;
          end
        end else begin
          dly--;
          bus.imem_ack = 1'b0;
          bus.imem_data = 8'($urandom);
        end
      end else begin
        chk("imem_req_idle", bus.imem_req, 0);
        bus.imem_ack = 1'($urandom);
        bus.imem_data = 8'($urandom);
      end
      if (halt_cyc >= 0 && cyc >= halt_cyc + 3) done = 1'b1;
    end
    start = 1'b0;
    bus.imem_ack = 1'b0;
    chk("run_complete", done, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = 8'h00;
    set_regs(8'h00, 8'h00);
    do_reset();

    // ADD r0 = r0 + r1, then HALT
    set_regs(8'd8, 8'd9);
    prog[0] = 8'h08;
    prog[1] = 8'hC0;
    run_prog(0, 0, 40);
    chk("add_wb_cycle", first_wb, 4);
    chk("add_r0", rf[0], 8'd17);
    chk("add_halt_pc", pc, 2);
    chk("add_halted", halted, 1);

    // LI r1 = 31
    do_reset();
    set_regs(8'd8, 8'd9);
    prog[0] = 8'b10111111;
    prog[1] = 8'hC0;
    run_prog(0, 0, 40);
    chk("li_r1", rf[1], 8'h1F);

    // SUB underflow and ADD overflow
    do_reset();
    set_regs(8'd8, 8'd9);
    prog[0] = 8'h48;
    prog[1] = 8'hC0;
    run_prog(0, 0, 40);
`ifdef INSTR_SEQ_SATURATE_EN
    chk("sub_under", rf[0], 8'h00);
`else
    chk("sub_under", rf[0], 8'hFF);
`endif
    do_reset();
    set_regs(8'hF0, 8'h20);
    prog[0] = 8'h08;
    prog[1] = 8'hC0;
    run_prog(0, 0, 40);
`ifdef INSTR_SEQ_SATURATE_EN
    chk("add_over", rf[0], 8'hFF);
`else
    chk("add_over", rf[0], 8'h10);
`endif

    // Ack delayed 3 cycles on every fetch
    do_reset();
    set_regs(8'($urandom), 8'($urandom));
    for (int i = 0; i < 5; i++) prog[i] = rnd_ins();
    prog[5] = 8'hC0;
    run_prog(3, 3, 200);

    // 257 instructions: pc wraps 255 -> 0 and ends at 2
    do_reset();
    set_regs(8'($urandom), 8'($urandom));
    for (int i = 0; i < 257; i++) prog[i] = rnd_ins();
    prog[257] = 8'hC0;
    run_prog(0, 0, 1200);
    chk("wrap_pc", pc, 2);

    // Random programs and random ack latency
    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      set_regs(8'($urandom), 8'($urandom));
      n = $urandom_range(20, 8);
      for (int i = 0; i < n; i++) prog[i] = rnd_ins();
      prog[n] = 8'hC0;
      run_prog(0, 2, 400);
    end

    // Reset during WRITEBACK
    do_reset();
    bus.imem_ack = 1'b1;
    bus.imem_data = 8'hBF;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10 && !bus.write_en; i++) @(negedge clock);
    chk("wbrst_reached", bus.write_en, 1);
    reset_n = 1'b0;
    #1;
    chk("wbrst_write_en", bus.write_en, 0);
    chk("wbrst_busy", busy, 0);
    chk("wbrst_pc", pc, 0);
    chk("wbrst_write_data", bus.write_data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("wbrst_idle_busy", busy, 0);
      chk("wbrst_idle_we", bus.write_en, 0);
      chk("wbrst_idle_pc", pc, 0);
    end

    // Reset during a stalled FETCH
    do_reset();
    bus.imem_ack = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("frst_req_before", bus.imem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("frst_req", bus.imem_req, 0);
    chk("frst_busy", busy, 0);
    chk("frst_addr", bus.imem_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.imem_ack = 1'b1;
    repeat (2) @(negedge clock);
    chk("frst_no_restart", busy, 0);
    bus.imem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
